// File: rtl/regarb_pkg.sv
// Shared encodings and the window range check for the register-file bus arbiter.
package regarb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } state_e;

   // Word-aligned and inside [base, base + 4*num); 18-bit math avoids wrap at the top of the map.
   function automatic logic addr_in_range(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input int unsigned num);
      logic [17:0] a, lo, hi;
      a  = {2'b00, addr};
      lo = {2'b00, base};
      hi = lo + 18'(num * 4);
      return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/regfile_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the master that was not granted last wins.
module rr_arb2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic grant_valid_o,
   output logic grant_id_o
);

   assign grant_valid_o = req0_i | req1_i;
   assign grant_id_o    = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/regfile_bus_arbiter.sv
// Two-master round-robin sequencer issuing one register-file access per grant with a registered response.
// Optional address window check enabled by defining REGARB_RANGE_CHK_EN.
module regfile_bus_arbiter
   import regarb_pkg::*;
#(
   parameter logic [15:0] REG_BASE_ADDR = 16'h0100,
   parameter int unsigned NUM           = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [15:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [15:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [15:0] rf_addr,
   output logic        rf_wr,
   output logic [31:0] rf_wdata,
   input  logic [31:0] rf_rdata,
   output logic        busy
);

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        oor_q, oor_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        err0_q, err0_d, err1_q, err1_d;
   logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic        grant_valid, grant_id;
   logic        sel_wr, sel_oor;
   logic [15:0] sel_addr;
   logic [31:0] sel_wdata, rd_val;

   rr_arb2 u_arb (
      .req0_i        (m0_req),
      .req1_i        (m1_req),
      .last_grant_i  (last_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   assign sel_wr    = (grant_id == M1) ? m1_wr    : m0_wr;
   assign sel_addr  = (grant_id == M1) ? m1_addr  : m0_addr;
   assign sel_wdata = (grant_id == M1) ? m1_wdata : m0_wdata;

`ifdef REGARB_RANGE_CHK_EN
   assign sel_oor = ~addr_in_range(sel_addr, REG_BASE_ADDR, NUM);
`else
   assign sel_oor = 1'b0;
`endif

   // Out-of-window reads return zero rather than whatever the register file decodes.
   assign rd_val = oor_q ? 32'h0 : rf_rdata;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      oor_d    = oor_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               gnt_d   = grant_id;
               last_d  = grant_id;
               wr_d    = sel_wr;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               oor_d   = sel_oor;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (gnt_q == M1) begin
               ack1_d = 1'b1;
               err1_d = oor_q;
               if (!wr_q) rdata1_d = rd_val;
            end else begin
               ack0_d = 1'b1;
               err0_d = oor_q;
               if (!wr_q) rdata0_d = rd_val;
            end
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         last_q   <= M1;
         gnt_q    <= M0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         oor_q    <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         oor_q    <= oor_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign rf_addr  = addr_q;
   assign rf_wdata = wdata_q;
   assign rf_wr    = (state_q == ACCESS) & wr_q & ~oor_q;
   assign busy     = (state_q != IDLE);
   assign m0_ack   = ack0_q;
   assign m1_ack   = ack1_q;
   assign m0_err   = err0_q;
   assign m1_err   = err1_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Directed bench for regfile_bus_arbiter with a small behavioural register file model.
module tb_regfile_bus_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [15:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [15:0] rf_addr;
   logic        rf_wr;
   logic [31:0] rf_wdata, rf_rdata;
   logic        busy;

   logic [31:0] mem [4];
   logic        frc;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   regfile_bus_arbiter dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .busy(busy)
   );

   // Register file: window 0x0100..0x010F, write on posedge, combinational read.
   always_comb begin
      rf_rdata = 32'hDEAD_BEEF;
      if (rf_addr[15:4] == 12'h010) rf_rdata = mem[rf_addr[3:2]];
      if (frc) rf_rdata = 32'h1234_5678;
   end

   always @(posedge clk)
      if (rf_wr && rf_addr[15:4] == 12'h010) mem[rf_addr[3:2]] <= rf_wdata;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic txn(input string tag, input logic m, input logic wr, input logic [15:0] a,
                      input logic [31:0] d, input logic exp_strobe, input logic [31:0] exp_rd,
                      input logic exp_err);
      @(negedge clk);
      if (m) begin m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d; end
      else   begin m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d; end
      @(negedge clk);
      chk({tag, ".access_rf_wr"}, {31'b0, rf_wr}, {31'b0, exp_strobe});
      chk({tag, ".access_rf_addr"}, {16'b0, rf_addr}, {16'b0, a});
      if (wr) chk({tag, ".access_rf_wdata"}, rf_wdata, d);
      chk({tag, ".access_busy_acks"}, {29'b0, busy, m0_ack, m1_ack}, 32'h4);
      @(negedge clk);
      chk({tag, ".resp_acks"}, {30'b0, m1_ack, m0_ack}, m ? 32'h2 : 32'h1);
      chk({tag, ".resp_rdata"}, m ? m1_rdata : m0_rdata, exp_rd);
      chk({tag, ".resp_err"}, {31'b0, m ? m1_err : m0_err}, {31'b0, exp_err});
      chk({tag, ".resp_rf_wr"}, {31'b0, rf_wr}, 32'h0);
      if (m) m1_req = 1'b0; else m0_req = 1'b0;
      @(negedge clk);
      chk({tag, ".idle"}, {29'b0, busy, m0_ack, m1_ack}, 32'h0);
   endtask

   initial begin
      int ack_id [8];
      int ack_cyc [8];
      int n0, n1, nack;
      rstn = 1'b0; frc = 1'b0;
      m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + i;
      #23 rstn = 1'b1;

      @(negedge clk);
      chk("reset.ctl", {28'b0, busy, rf_wr, m0_ack, m1_ack}, 32'h0);
      chk("reset.rf_addr", {16'b0, rf_addr}, 32'h0);
      chk("reset.rf_wdata", rf_wdata, 32'h0);
      chk("reset.rdata_err", m0_rdata | m1_rdata | {30'b0, m0_err, m1_err}, 32'h0);

      txn("m0_wr104", 1'b0, 1'b1, 16'h0104, 32'hA5A5_0007, 1'b1, 32'h0, 1'b0);
      chk("m0_wr104.mem", mem[1], 32'hA5A5_0007);
      txn("m1_rd104", 1'b1, 1'b0, 16'h0104, 32'h0, 1'b0, 32'hA5A5_0007, 1'b0);

      frc = 1'b1;
      txn("m0_rd_forced", 1'b0, 1'b0, 16'h010C, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
      frc = 1'b0;
      txn("m0_wr_keep", 1'b0, 1'b1, 16'h0108, 32'h0000_0055, 1'b1, 32'h1234_5678, 1'b0);
      chk("m0_wr_keep.mem", mem[2], 32'h0000_0055);

`ifdef REGARB_RANGE_CHK_EN
      txn("m0_wr110", 1'b0, 1'b1, 16'h0110, 32'hFFFF_0000, 1'b0, 32'h1234_5678, 1'b1);
      txn("m0_rd102", 1'b0, 1'b0, 16'h0102, 32'h0, 1'b0, 32'h0, 1'b1);
`else
      txn("m0_wr110", 1'b0, 1'b1, 16'h0110, 32'hFFFF_0000, 1'b1, 32'h1234_5678, 1'b0);
      txn("m0_rd102", 1'b0, 1'b0, 16'h0102, 32'h0, 1'b0, 32'h1000_0000, 1'b0);
`endif

      // Reset pulse while an m1 read is in ACCESS.
      @(negedge clk);
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0104;
      @(negedge clk);
      chk("rst_mid.in_access", {31'b0, busy}, 32'h1);
      rstn = 1'b0;
      #1;
      chk("rst_mid.ctl", {28'b0, busy, rf_wr, m0_ack, m1_ack}, 32'h0);
      chk("rst_mid.rf_addr", {16'b0, rf_addr}, 32'h0);
      chk("rst_mid.rdata", m0_rdata | m1_rdata, 32'h0);
      m1_req = 1'b0;
      #2 rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid.no_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
      end
      txn("post_rst_m1_rd", 1'b1, 1'b0, 16'h0104, 32'h0, 1'b0, 32'hA5A5_0007, 1'b0);

      // Both masters request out of reset: m0 first, then strict alternation.
      @(negedge clk);
      rstn = 1'b0;
      #2 rstn = 1'b1;
      @(negedge clk);
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0100;
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0108;
      n0 = 0; n1 = 0; nack = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m0_ack && m1_ack) chk("rr.both_acks", 32'h3, 32'h0);
         if ((m0_ack || m1_ack) && nack < 8) begin
            ack_id[nack] = m1_ack ? 1 : 0;
            ack_cyc[nack] = c;
            nack++;
            if (m0_ack) begin n0++; if (n0 == 4) m0_req = 1'b0; end
            if (m1_ack) begin n1++; if (n1 == 4) m1_req = 1'b0; end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      chk("rr.ack_count", nack, 8);
      for (int k = 0; k < nack; k++) begin
         chk("rr.order", ack_id[k], k % 2);
         if (k > 0) chk("rr.spacing", ack_cyc[k] - ack_cyc[k-1], 3);
      end
      chk("rr.m0_rdata", m0_rdata, 32'h1000_0000);
      chk("rr.m1_rdata", m1_rdata, 32'h0000_0055);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_bus_arbiter.md
Name: regfile_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the APB-side register file (flat addr/wr/wdata/rdata bus, write on posedge, combinational read).
- Accepts single-beat read/write requests from master 0 (APB slave bridge) and master 1 (debug/UART command engine).
- Grants round-robin, drives exactly one register-file access per grant, and returns a registered response.

Parameters:
- REG_BASE_ADDR, 16'h0100, base byte address of the register window (range check only).
- NUM, 4, number of 32-bit registers in the window (range check only).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_wr  in  1  master 0: 1=write, 0=read
- m0_addr  in  16  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_ack  out  1  master 0 one-cycle completion pulse
- m0_rdata  out  32  master 0 read data, valid with m0_ack
- m0_err  out  1  master 0 error, valid with m0_ack
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as m0_* for master 1
- rf_addr  out  16  register-file address
- rf_wr  out  1  register-file write strobe
- rf_wdata  out  32  register-file write data
- rf_rdata  in  32  register-file read data (combinational from rf_addr)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous: rstn, active-low; clock is clk.
- Reset values:
  - state=IDLE, last_grant=1 (so master 0 wins the first tie).
  - rf_addr=0, rf_wr=0, rf_wdata=0.
  - m*_ack=0, m*_rdata=0, m*_err=0, busy=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the master that is not last_grant.
  - On the grant edge, latch wr/addr/wdata into rf_wr_q/rf_addr/rf_wdata, update last_grant, and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (1 cycle):
  - rf_addr and rf_wdata are driven from the latched values.
  - rf_wr=1 only for a write.
  - At the end-of-cycle edge:
    - the register file commits the write;
    - for a read, rf_rdata is captured into the granted master's m*_rdata;
    - ack=1 is registered for the granted master;
    - state goes to RESP.
- RESP (1 cycle):
  - The granted master's m*_ack=1; the other master's ack stays 0.
  - At the next edge, ack clears and state goes to IDLE.
- Latency: request seen at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Throughput is one access per 3 cycles.
- Requester rule: drop req at the same edge where ack is sampled high. A req still high in the following IDLE is a new transaction.
- Both masters requesting continuously alternate 0,1,0,1.
- rf_wr is high only in ACCESS, never two consecutive cycles.
- Data-holding rules:
  - rf_addr and rf_wdata hold their last values outside ACCESS.
  - m*_rdata holds until that master's next read.
  - A write does not modify m*_rdata.
- Changes to req, addr or wdata of a master while it is not granted have no effect until IDLE.
- Reset asserted mid-transaction: immediate return to reset values, the pending transaction is dropped, and no ack is issued. A write is committed only if its ACCESS edge completed before reset.

Optional Feature:
- Macro: REGARB_RANGE_CHK_EN.
- Defined: an address is in range iff REG_BASE_ADDR <= addr < REG_BASE_ADDR+4*NUM and addr[1:0]==0. An out-of-range transaction:
  - still passes through ACCESS/RESP with identical timing;
  - has rf_wr forced to 0;
  - returns m*_rdata=0 for reads;
  - asserts m*_err=1 with ack.
- Undefined: there is no check, all transactions are forwarded, and m*_err is tied to 0.

Decomposition:
- Package regarb_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - master id constants M0=1'b0, M1=1'b1.
- One sub-module, rr_arb2: pure combinational 2-way round-robin pick from (req0, req1, last_grant) producing grant_valid and grant_id. The FSM, latches and response registers stay in the top.

Test Plan:
- m0 write addr=16'h0104, wdata=32'hA5A5_0007 -> rf_wr high exactly one cycle with rf_addr=0104 and rf_wdata=A5A50007; m0_ack 2 cycles after req sampled; m1_ack stays 0.
- m1 read addr=16'h0104 after the above -> m1_rdata=32'hA5A5_0007 with m1_ack; rf_wr stays 0 throughout.
- m0 and m1 both request first out of reset, req held for 4 transactions each -> grant order m0,m1,m0,m1...; each ack spaced 3 cycles apart.
- rstn pulsed low during ACCESS of an m1 read -> no m1_ack; all outputs return to reset values asynchronously; next request after reset is granted normally.
- With REGARB_RANGE_CHK_EN: m0 write addr=16'h0110 -> rf_wr stays 0, m0_ack with m0_err=1; read addr=16'h0102 -> m0_rdata=0, m0_err=1. Without the macro: the same write strobes rf_wr and m0_err=0.
- m0 read while rf_rdata is forced to 32'h1234_5678 -> m0_rdata=32'h1234_5678; a subsequent m0 write leaves m0_rdata unchanged.
